// File: rtl/note_recorder.sv
// Keyboard capture into an on-chip event buffer: run-length encodes synchronized
// (note, octave) into {note, octave, duration} entries with a registered read port.
module note_recorder #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int DEPTH       = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rec_enable,
    input  logic [6:0]  key_in,
    input  logic [1:0]  octave_keys,
    input  logic [5:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [6:0]  count,
    output logic        full,
    output logic        recording
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [9:0]    TICK_MAX = 10'd1023;

    typedef enum logic [1:0] {IDLE, WAIT_FIRST, CAPTURE} state_t;

    state_t state, next_state;

    logic [6:0]    key_s1, key_s2;
    logic [1:0]    oct_s1, oct_s2;
    logic          rec_s1, rec_s2, rec_prev;
    logic          vld_s1, vld_s2;
    logic [2:0]    cur_note;
    logic [1:0]    cur_oct;
    logic          rec_rise;

    logic [2:0]    ev_note;
    logic [1:0]    ev_oct;
    logic [CW-1:0] cyc;
    logic [9:0]    ticks;
    logic [9:0]    dur_close;
    logic          tick_wrap, ev_changed;
    logic [AW-1:0] wr_ptr;
    logic [15:0]   mem [DEPTH];

    logic start_session, open_event, run_event, close_event, do_write;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1   <= '0;
            key_s2   <= '0;
            oct_s1   <= '0;
            oct_s2   <= '0;
            rec_s1   <= 1'b0;
            rec_s2   <= 1'b0;
            vld_s1   <= 1'b0;
            vld_s2   <= 1'b0;
            rec_prev <= 1'b1;
        end else begin
            key_s1   <= key_in;
            key_s2   <= key_s1;
            oct_s1   <= octave_keys;
            oct_s2   <= oct_s1;
            rec_s1   <= rec_enable;
            rec_s2   <= rec_s1;
            vld_s1   <= 1'b1;
            vld_s2   <= vld_s1;
            // Until the synchronizer holds a real sample, pretend the level was high,
            // so a rec_enable already asserted at reset release is not seen as a rise.
            rec_prev <= vld_s2 ? rec_s2 : 1'b1;
        end
    end

    assign rec_rise = vld_s2 & rec_s2 & ~rec_prev;
    assign cur_oct  = oct_s2;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cur_note = '0;
        for (int i = 6; i >= 0; i--) begin
            if (key_s2[i]) cur_note = 3'(i + 1);
        end
    end

    // The closing edge credits the final held cycle, so duration = floor(held / TICK_CYCLES).
    assign tick_wrap  = (cyc == CYC_LAST);
    assign dur_close  = (tick_wrap && ticks != TICK_MAX) ? ticks + 10'd1 : ticks;
    assign ev_changed = (cur_note != ev_note) || (cur_oct != ev_oct);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        start_session = 1'b0;
        open_event    = 1'b0;
        run_event     = 1'b0;
        close_event   = 1'b0;
        case (state)
            IDLE: begin
                if (rec_rise) begin
                    start_session = 1'b1;
                    next_state    = WAIT_FIRST;
                end
            end
            WAIT_FIRST: begin
                if (!rec_s2) begin
                    next_state = IDLE;
                end else if (cur_note != 3'd0) begin
                    open_event = 1'b1;
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!rec_s2) begin
                    close_event = (ev_note != 3'd0) && (dur_close != 10'd0);
                    next_state  = IDLE;
                end else if (ev_changed) begin
                    close_event = (dur_close != 10'd0);
                    open_event  = 1'b1;
                end else begin
                    run_event = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign full      = (count == 7'(DEPTH));
    assign recording = (state != IDLE);
    assign do_write  = close_event & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            wr_ptr  <= '0;
            ev_note <= '0;
            ev_oct  <= '0;
            cyc     <= '0;
            ticks   <= '0;
            rd_data <= '0;
        end else begin
            if (start_session) begin
                count  <= '0;
                wr_ptr <= '0;
            end else if (do_write) begin
                count  <= count + 7'd1;
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (open_event) begin
                ev_note <= cur_note;
                ev_oct  <= cur_oct;
                cyc     <= '0;
                ticks   <= '0;
            end else if (run_event) begin
                if (tick_wrap) begin
                    cyc <= '0;
                    if (ticks != TICK_MAX) ticks <= ticks + 10'd1;
                end else begin
                    cyc <= cyc + CW'(1);
                end
            end

            rd_data <= ({1'b0, rd_addr} < count) ? mem[rd_addr[AW-1:0]] : '0;
        end
    end

    // NOTE: the event buffer has no reset; count gates every read, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= {1'b0, ev_note, ev_oct, dur_close};
    end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder: directed scenarios plus random sessions, compared against a
// run-length model of the pin history seen since the last reset.
module tb_note_recorder;

    localparam int TICK  = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset = 1'b0;
    logic        rec_enable = 1'b0;
    logic [6:0]  key_in = '0;
    logic [1:0]  octave_keys = '0;
    logic [5:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic [6:0]  count;
    logic        full;
    logic        recording;

    int vectors = 0;
    int miscompares = 0;

    bit          h_rec[$];
    logic [2:0]  h_note[$];
    logic [1:0]  h_oct[$];

    int          exp_count;
    logic [15:0] exp_mem [DEPTH];

    typedef struct {
        logic [2:0] note;
        logic [1:0] oct;
        int         len;
    } run_t;

    note_recorder #(.TICK_CYCLES(TICK), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rec_enable (rec_enable),
        .key_in     (key_in),
        .octave_keys(octave_keys),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .count      (count),
        .full       (full),
        .recording  (recording)
    );

    always #5 if (clk_run) clk = ~clk;

    function automatic logic [2:0] pin_note(input logic [6:0] k);
        for (int i = 0; i < 7; i++) begin
            if (k[i]) return 3'(i + 1);
        end
        return 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            h_rec.push_back(rec_enable);
            h_note.push_back(pin_note(key_in));
            h_oct.push_back(octave_keys);
        end
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_history();
        h_rec.delete();
        h_note.delete();
        h_oct.delete();
    endtask

    // Sample k (1-based) is the pin value at edge k; the design has acted on samples 1..size-2.
    function automatic void build_model();
        int   m = h_rec.size() - 2;
        int   r = 0;
        int   g;
        bit   closed;
        bit   started = 0;
        run_t runs[$];
        exp_count = 0;
        for (int d = 0; d < DEPTH; d++) exp_mem[d] = '0;
        for (int k = 2; k <= m; k++) begin
            if (h_rec[k-1] && !h_rec[k-2]) r = k;
        end
        if (r == 0) return;
        g = m + 1;
        for (int k = r + 1; k <= m; k++) begin
            if (!h_rec[k-1]) begin
                g = k;
                break;
            end
        end
        closed = (g <= m);
        for (int k = r + 1; k < g; k++) begin
            if (!started && h_note[k-1] == 3'd0) continue;
            started = 1;
            if (runs.size() > 0 && runs[runs.size()-1].note == h_note[k-1] &&
                runs[runs.size()-1].oct == h_oct[k-1])
                runs[runs.size()-1].len += 1;
            else
                runs.push_back('{h_note[k-1], h_oct[k-1], 1});
        end
        for (int i = 0; i < runs.size(); i++) begin
            bit last = (i == runs.size() - 1);
            int dur  = runs[i].len / TICK;
            if (dur > 1023) dur = 1023;
            if (last && !closed) break;
            if (last && runs[i].note == 3'd0) continue;
            if (dur == 0) continue;
            if (exp_count < DEPTH) begin
                exp_mem[exp_count] = {1'b0, runs[i].note, runs[i].oct, 10'(dur)};
                exp_count++;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        build_model();
        check({tag, ":count"}, 16'(count), 16'(exp_count));
        check({tag, ":full"}, 16'(full), 16'(exp_count == DEPTH));
    endtask

    task automatic check_reads(input string tag);
        build_model();
        for (int a = 0; a <= DEPTH; a++) begin
            logic [15:0] e;
            e = '0;
            if (a < exp_count) e = exp_mem[a];
            rd_addr = 6'(a);
            tick();
            check($sformatf("%s:rd%0d", tag, a), rd_data, e);
        end
    endtask

    task automatic start_session();
        rec_enable = 1'b0;
        key_in     = '0;
        ticks(3);
        rec_enable = 1'b1;
        ticks(4);
    endtask

    task automatic hold(input logic [6:0] k, input logic [1:0] o, input int n);
        key_in      = k;
        octave_keys = o;
        ticks(n);
    endtask

    task automatic end_session();
        rec_enable = 1'b0;
        key_in     = '0;
        ticks(5);
    endtask

    initial begin
        // Reset with no clock running, rec_enable already high.
        rec_enable = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("reset:count", 16'(count), 16'd0);
        check("reset:full", 16'(full), 16'd0);
        check("reset:recording", 16'(recording), 16'd0);
        check("reset:rd_data", rd_data, 16'd0);
        clk_run = 1'b1;
        ticks(3);
        reset = 1'b0;
        clear_history();
        ticks(6);
        check("reset:stay_idle", 16'(recording), 16'd0);
        check_state("reset");

        // Single note then rest.
        start_session();
        check("single:recording", 16'(recording), 16'd1);
        hold(7'b0000001, 2'b01, 10);
        hold(7'b0000000, 2'b01, 6);
        check_state("single");
        check_reads("single");
        rd_addr = 6'd0;
        tick();
        check("single:const_data", rd_data, 16'h1402);
        check("single:const_count", 16'(count), 16'd1);

        // Glitch filter in a fresh session.
        end_session();
        start_session();
        hold(7'b0000100, 2'b00, 3);
        hold(7'b0000000, 2'b00, 2);
        check("glitch:count_after_glitch", 16'(count), 16'd0);
        hold(7'b0000100, 2'b00, 8);
        hold(7'b0000000, 2'b00, 6);
        check_state("glitch");
        check_reads("glitch");
        rd_addr = 6'd0;
        tick();
        check("glitch:const_data", rd_data, 16'h3002);

        // Full buffer: five alternating events, only four fit.
        end_session();
        start_session();
        hold(7'b0000001, 2'b10, 8);
        hold(7'b0000000, 2'b10, 8);
        hold(7'b0010000, 2'b11, 8);
        hold(7'b0000000, 2'b11, 8);
        hold(7'b1000000, 2'b01, 8);
        end_session();
        check_state("full");
        check("full:const_count", 16'(count), 16'd4);
        check("full:const_flag", 16'(full), 16'd1);
        check_reads("full");
        rd_addr = 6'd4;
        tick();
        check("full:const_rd4", rd_data, 16'd0);

        // Session close flushes the open note; recording drops three edges later.
        start_session();
        hold(7'b1000000, 2'b10, 8);
        rec_enable = 1'b0;
        key_in     = '0;
        tick();
        check("close:rec_edge1", 16'(recording), 16'd1);
        tick();
        check("close:rec_edge2", 16'(recording), 16'd1);
        tick();
        check("close:rec_edge3", 16'(recording), 16'd0);
        ticks(2);
        check_state("close");
        check_reads("close");
        rd_addr = 6'd0;
        tick();
        check("close:const_data", rd_data, 16'h7802);

        // Trailing rest is not stored.
        start_session();
        hold(7'b0000010, 2'b01, 8);
        hold(7'b0000000, 2'b01, 8);
        end_session();
        check("trail:const_count", 16'(count), 16'd1);
        check_state("trail");
        check_reads("trail");

        // Reset mid-capture aborts the open event.
        start_session();
        hold(7'b0001000, 2'b00, 6);
        reset = 1'b1;
        #1;
        check("midrst:recording", 16'(recording), 16'd0);
        check("midrst:count", 16'(count), 16'd0);
        check("midrst:rd_data", rd_data, 16'd0);
        ticks(2);
        reset = 1'b0;
        clear_history();
        key_in = '0;
        ticks(4);
        check_state("midrst");
        check_reads("midrst");

        // Random sessions.
        for (int s = 0; s < 8; s++) begin
            int nseg;
            start_session();
            nseg = $urandom_range(3, 7);
            for (int j = 0; j < nseg; j++) begin
                logic [6:0] k;
                k = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                hold(k, 2'($urandom_range(0, 3)), $urandom_range(1, 12));
            end
            if ($urandom_range(0, 1) == 1) begin
                key_in = '0;
                ticks(4);
                check_state($sformatf("rand%0d_mid", s));
            end
            end_session();
            check_state($sformatf("rand%0d", s));
            check_reads($sformatf("rand%0d", s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
